// File: rtl/chunked_addsub.sv
// Multi-cycle add/subtract unit: adds CHUNK bits per cycle with a ripple carry
// held between cycles, valid/ready handshakes on both sides, and result flags.
module chunked_addsub #(
  parameter int WIDTH = 10,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg,
  output logic             lt_u
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [IDXW-1:0]  idx_r;
  logic [WIDTH-1:0] op_a_r;
  logic [WIDTH-1:0] op_b_r;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] acc_s;
  logic [WIDTH-1:0] result_r;
  logic             op_r;
  logic             carry_r;
  logic             cout_r;
  logic             ovf_r;
  logic             zero_r;
  logic             neg_r;
  logic             lt_u_r;
  logic [CHUNK:0]   sum_s;
  logic             last_s;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state flop
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_r)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // One chunk of the ripple add, merged into the working accumulator
  always_comb begin
    sum_s = {1'b0, op_a_r[idx_r*CHUNK +: CHUNK]}
          + {1'b0, op_b_r[idx_r*CHUNK +: CHUNK]}
          + {{CHUNK{1'b0}}, carry_r};
    acc_s = acc_r;
    acc_s[idx_r*CHUNK +: CHUNK] = sum_s[CHUNK-1:0];
    last_s = (idx_r == IDXW'(NCHUNK - 1));
  end

  // Operand capture, chunk stepping and result/flag registers.
  // The visible result only changes on completion; partial sums live in acc_r.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r    <= '0;
      op_a_r   <= '0;
      op_b_r   <= '0;
      acc_r    <= '0;
      op_r     <= 1'b0;
      carry_r  <= 1'b0;
      result_r <= '0;
      cout_r   <= 1'b0;
      ovf_r    <= 1'b0;
      zero_r   <= 1'b0;
      neg_r    <= 1'b0;
      lt_u_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            op_a_r  <= a;
            op_b_r  <= op_sub ? ~b : b;
            op_r    <= op_sub;
            carry_r <= op_sub;
            idx_r   <= '0;
          end
        end
        RUN: begin
          acc_r   <= acc_s;
          carry_r <= sum_s[CHUNK];
          if (last_s) begin
            result_r <= acc_s;
            cout_r   <= sum_s[CHUNK];
            ovf_r    <= (op_a_r[WIDTH-1] == op_b_r[WIDTH-1]) &&
                        (acc_s[WIDTH-1] != op_a_r[WIDTH-1]);
            zero_r   <= (acc_s == '0);
            neg_r    <= acc_s[WIDTH-1];
            lt_u_r   <= op_r & ~sum_s[CHUNK];
          end else begin
            idx_r <= idx_r + IDXW'(1);
          end
        end
        default: begin
          idx_r <= idx_r;
        end
      endcase
    end
  end

  assign result = result_r;
  assign cout   = cout_r;
  assign ovf    = ovf_r;
  assign zero   = zero_r;
  assign neg    = neg_r;
  assign lt_u   = lt_u_r;

endmodule

// File: tb/tb_chunked_addsub.sv
// Directed checks of chunked_addsub at the default size, plus a random sweep
// of WIDTH=16 instances with CHUNK=16/4/1 against an integer reference model.
module tb_chunked_addsub;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [9:0] a = 10'd0;
  logic [9:0] b = 10'd0;
  logic       op_sub = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [9:0] result;
  logic       cout, ovf, zero, neg, lt_u;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  chunked_addsub #(.WIDTH(10), .CHUNK(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op_sub(op_sub), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .ovf(ovf), .zero(zero), .neg(neg), .lt_u(lt_u)
  );

  // WIDTH=16 sweep instances: index 0 -> CHUNK 16, 1 -> CHUNK 4, 2 -> CHUNK 1
  logic        sw_iv  [3];
  logic        sw_ir  [3];
  logic [15:0] sw_a   [3];
  logic [15:0] sw_b   [3];
  logic        sw_op  [3];
  logic        sw_ov  [3];
  logic        sw_or  [3];
  logic [15:0] sw_res [3];
  logic        sw_c   [3];
  logic        sw_o   [3];
  logic        sw_z   [3];
  logic        sw_n   [3];
  logic        sw_l   [3];

  for (genvar g = 0; g < 3; g++) begin : g_sweep
    chunked_addsub #(.WIDTH(16), .CHUNK((g == 0) ? 16 : ((g == 1) ? 4 : 1))) u_dut (
      .clk(clk), .rst(rst), .in_valid(sw_iv[g]), .in_ready(sw_ir[g]),
      .a(sw_a[g]), .b(sw_b[g]), .op_sub(sw_op[g]), .out_valid(sw_ov[g]),
      .out_ready(sw_or[g]), .result(sw_res[g]), .cout(sw_c[g]), .ovf(sw_o[g]),
      .zero(sw_z[g]), .neg(sw_n[g]), .lt_u(sw_l[g])
    );
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] flags10();
    return 32'({cout, ovf, zero, neg, lt_u});
  endfunction

  // Present one operation on the default DUT, return edges until out_valid
  task automatic run_op(input logic [9:0] ta, input logic [9:0] tb_v, input logic top,
                        output int lat);
    check_eq("in_ready_before_op", 32'(in_ready), 32'd1);
    a = ta; b = tb_v; op_sub = top; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic directed(input string tag, input logic [9:0] ta, input logic [9:0] tb_v,
                          input logic top, input logic [9:0] exp_res, input logic [4:0] exp_f);
    int lat;
    run_op(ta, tb_v, top, lat);
    check_eq({tag, "_latency"}, 32'(lat), 32'd5);
    check_eq({tag, "_result"}, 32'(result), 32'(exp_res));
    check_eq({tag, "_flags"}, flags10(), 32'(exp_f));
    release_result();
  endtask

  // Reference: {result[15:0], cout, ovf, zero, neg, lt_u} from integer arithmetic
  function automatic logic [20:0] ref16(input logic [15:0] x, input logic [15:0] y, input logic s);
    int sx, sy, sr, ux, uy, ur;
    logic [15:0] r;
    logic c, o;
    sx = int'($signed(x)); sy = int'($signed(y));
    ux = int'(x);          uy = int'(y);
    sr = s ? (sx - sy) : (sx + sy);
    ur = s ? (ux - uy) : (ux + uy);
    r  = ur[15:0];
    o  = (sr > 32767) || (sr < -32768);
    c  = s ? (ux >= uy) : (ur > 65535);
    return {r, c, o, (r == 16'd0), r[15], s & ~c};
  endfunction

  task automatic sweep(input int k, input int nch);
    int lat;
    logic [15:0] ra, rb;
    logic rop;
    logic [20:0] exp_v;
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rop = 1'($urandom_range(1, 0));
      if (i == 0) begin ra = 16'h7FFF; rb = 16'h0001; rop = 1'b0; end
      if (i == 1) begin ra = 16'h8000; rb = 16'h0001; rop = 1'b1; end
      if (i == 2) begin ra = 16'h1234; rb = 16'h1234; rop = 1'b1; end
      exp_v = ref16(ra, rb, rop);
      sw_a[k] = ra; sw_b[k] = rb; sw_op[k] = rop; sw_iv[k] = 1'b1;
      @(posedge clk); #1;
      sw_iv[k] = 1'b0;
      lat = 0;
      while (!sw_ov[k] && lat < 50) begin
        @(posedge clk); #1;
        lat++;
      end
      check_eq("sweep_latency", 32'(lat), 32'(nch));
      check_eq("sweep_result_flags",
               32'({sw_res[k], sw_c[k], sw_o[k], sw_z[k], sw_n[k], sw_l[k]}), 32'(exp_v));
      sw_or[k] = 1'b1;
      @(posedge clk); #1;
      sw_or[k] = 1'b0;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int ov_seen;
    int bp_bad;
    for (int k = 0; k < 3; k++) begin
      sw_iv[k] = 1'b0; sw_a[k] = 16'd0; sw_b[k] = 16'd0; sw_op[k] = 1'b0; sw_or[k] = 1'b0;
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_eq("reset_in_ready", 32'(in_ready), 32'd1);
    check_eq("reset_out_valid", 32'(out_valid), 32'd0);
    check_eq("reset_result", 32'(result), 32'd0);
    check_eq("reset_flags", flags10(), 32'd0);

    // Flags order: {cout, ovf, zero, neg, lt_u}
    directed("add_300_200", 10'd300, 10'd200, 1'b0, 10'd500, 5'b00000);
    directed("sub_5_7", 10'd5, 10'd7, 1'b1, 10'h3FE, 5'b00011);
    directed("sub_0_0", 10'd0, 10'd0, 1'b1, 10'd0, 5'b10100);
    directed("add_511_1", 10'd511, 10'd1, 1'b0, 10'd512, 5'b01010);

    // Backpressure: hold the result, ignore a new request during DONE
    run_op(10'd5, 10'd7, 1'b1, lat);
    check_eq("bp_latency", 32'(lat), 32'd5);
    bp_bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin a = 10'd1; b = 10'd1; op_sub = 1'b0; in_valid = 1'b1; end
      if (i == 4) in_valid = 1'b0;
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 10'h3FE || flags10() !== 32'd3)
        bp_bad++;
    end
    check_eq("bp_hold_errors", 32'(bp_bad), 32'd0);
    release_result();
    check_eq("bp_in_ready_after", 32'(in_ready), 32'd1);
    check_eq("bp_out_valid_after", 32'(out_valid), 32'd0);
    check_eq("bp_result_kept", 32'(result), 32'h3FE);
    repeat (3) @(posedge clk);
    #1 check_eq("bp_pulse_ignored", 32'(out_valid), 32'd0);

    // Reset in the middle of RUN (accept at edge 0, reset sampled at edge 3)
    a = 10'd1000; b = 10'd23; op_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("midrst_in_ready", 32'(in_ready), 32'd1);
    check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
    check_eq("midrst_result", 32'(result), 32'd0);
    check_eq("midrst_flags", flags10(), 32'd0);
    ov_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) ov_seen++;
    end
    check_eq("midrst_no_out_valid", 32'(ov_seen), 32'd0);
    directed("after_rst_3_4", 10'd3, 10'd4, 1'b0, 10'd7, 5'b00000);

    // Parameter sweep
    sweep(0, 1);
    sweep(1, 4);
    sweep(2, 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
